// File: rtl/pulse_safety_monitor.sv
// pulse_safety_monitor
// Watches the laser trigger, measures high time and rising-edge period in
// ticks of TICK_DIV clocks, and drops laser_enable with a sticky fault on
// any limit violation. monitor_status is read back through the register bank.
module pulse_safety_monitor #(
    parameter int TICK_DIV    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_in,
    input  logic [31:0] pulse_width_lower_limit,
    input  logic [31:0] pulse_width_upper_limit,
    input  logic [31:0] rate_lower_limit,
    input  logic        monitor_enable,
    input  logic        fault_clear,
    output logic        laser_enable,
    output logic [7:0]  monitor_status,
    output logic [31:0] last_width,
    output logic [31:0] last_period
);
    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [31:0]     CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_DISARMED,
        S_WAIT_FIRST,
        S_HIGH,
        S_LOW,
        S_FAULT
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   trig_s, trig_q, rise, fall;
    logic                   clr_q, clr_edge, en_q;
    logic [PW-1:0]          presc;
    logic                   tick;
    logic [31:0]            width_cnt, width_nxt, period_cnt, period_nxt;
    logic                   v_long, v_short, v_rate;
    logic [2:0]             flt_bits, bits_nxt;
    logic                   flt_any, any_nxt;
    logic                   armed, armed_nxt;
    logic                   cap_width, cap_period;

    assign trig_s = sync_ff[SYNC_STAGES-1];
    assign tick   = (presc == PRESC_MAX);

    // Synchronizer chain for the asynchronous trigger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_ff <= '0;
        else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], trig_in};
    end

    // Registered edge detectors (trigger and fault_clear) and enable sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q   <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            clr_q    <= 1'b0;
            clr_edge <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            trig_q   <= trig_s;
            rise     <= trig_s & ~trig_q;
            fall     <= ~trig_s & trig_q;
            clr_q    <= fault_clear;
            clr_edge <= fault_clear & ~clr_q;
            en_q     <= monitor_enable;
        end
    end

    // Free-running tick prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Next counter values: rise restarts both, ticks advance them with saturation.
    // trig_q is aligned with rise/fall, so the width covers exactly the high phase.
    always_comb begin
        width_nxt  = width_cnt;
        period_nxt = period_cnt;
        if (rise) begin
            width_nxt  = '0;
            period_nxt = '0;
        end else if (tick) begin
            if (trig_q && width_cnt != CNT_MAX) width_nxt  = width_cnt + 32'd1;
            if (period_cnt != CNT_MAX)          period_nxt = period_cnt + 32'd1;
        end
    end

    // Width/period counters, frozen while a fault is latched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_cnt  <= '0;
            period_cnt <= '0;
        end else if (state != S_FAULT) begin
            width_cnt  <= width_nxt;
            period_cnt <= period_nxt;
        end
    end

    // Limit checks; the long check looks at the value about to be stored so
    // the fault lands one clock after the violating tick
    always_comb begin
        v_long  = en_q && (state == S_HIGH) && (width_nxt > pulse_width_upper_limit);
        v_short = en_q && (state == S_HIGH) && fall && (width_cnt < pulse_width_lower_limit);
        v_rate  = en_q && (state == S_LOW) && rise && (period_cnt < rate_lower_limit);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_DISARMED;
        else     state <= next_state;
    end

    // FSM next-state logic; disabling wins over everything
    always_comb begin
        next_state = state;
        if (!en_q) begin
            next_state = S_DISARMED;
        end else begin
            case (state)
                S_DISARMED:   next_state = S_WAIT_FIRST;
                S_WAIT_FIRST: if (rise) next_state = S_HIGH;
                S_HIGH: begin
                    if (v_long || v_short) next_state = S_FAULT;
                    else if (fall)         next_state = S_LOW;
                end
                S_LOW: begin
                    if (v_rate)    next_state = S_FAULT;
                    else if (rise) next_state = S_HIGH;
                end
                S_FAULT:      if (clr_edge) next_state = S_WAIT_FIRST;
                default:      next_state = S_DISARMED;
            endcase
        end
    end

    // Output decode: a new violation overrides a coincident clear
    always_comb begin
        bits_nxt   = (clr_edge ? 3'b000 : flt_bits) | {v_rate, v_long, v_short};
        any_nxt    = (clr_edge ? 1'b0 : flt_any) | v_rate | v_long | v_short;
        armed_nxt  = (next_state == S_WAIT_FIRST) || (next_state == S_HIGH) ||
                     (next_state == S_LOW);
        cap_width  = (state == S_HIGH) && fall;
        cap_period = (state == S_LOW) && rise;
    end

    // Registered outputs: sticky fault bits, armed flag, captured measurements
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_bits    <= '0;
            flt_any     <= 1'b0;
            armed       <= 1'b0;
            last_width  <= '0;
            last_period <= '0;
        end else begin
            flt_bits <= bits_nxt;
            flt_any  <= any_nxt;
            armed    <= armed_nxt;
            if (cap_width)  last_width  <= width_cnt;
            if (cap_period) last_period <= period_cnt;
        end
    end

    assign laser_enable   = armed;
    assign monitor_status = {2'b00, trig_s, armed, flt_any, flt_bits};

endmodule

// File: tb/tb_pulse_safety_monitor.sv
// Bench for pulse_safety_monitor: event-level reference model (pulse widths
// and periods in ticks computed from drive times), per-cycle compare once the
// outputs have settled, plus literal status values for the directed scenarios.
`timescale 1ns/1ps
module tb_pulse_safety_monitor;
    localparam int S_DIS = 0, S_WAIT = 1, S_HIGH = 2, S_LOW = 3, S_FAULT = 4;

    logic        clk = 1'b0;
    logic        rst, trig_in, monitor_enable, fault_clear;
    logic [31:0] pwu, pwl, rlim;
    logic        laser_enable;
    logic [7:0]  monitor_status;
    logic [31:0] last_width, last_period;

    pulse_safety_monitor #(.TICK_DIV(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .trig_in(trig_in),
        .pulse_width_lower_limit(pwl), .pulse_width_upper_limit(pwu),
        .rate_lower_limit(rlim), .monitor_enable(monitor_enable),
        .fault_clear(fault_clear), .laser_enable(laser_enable),
        .monitor_status(monitor_status), .last_width(last_width),
        .last_period(last_period)
    );

    always #20 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0;
    int last_evt = 0;
    bit mute = 1'b0;

    // reference model
    int       m_state = S_DIS;
    logic [2:0] m_bits = '0;
    logic     m_any = 1'b0;
    logic     m_trig = 1'b0;
    int       m_lw = 0, m_lp = 0;
    int       rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic m_armed();
        return (m_state == S_WAIT) || (m_state == S_HIGH) || (m_state == S_LOW);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_near(input string name, input logic [31:0] act, input int exp);
        longint a;
        a = longint'(act);
        checks++;
        if (a > exp + 1 || a < exp - 1) begin
            errors++;
            $display("FAIL %s: got %0d want %0d+-1 (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model once everything has settled
    always @(negedge clk) begin : cmp
        logic [7:0] es;
        if (!mute && (cyc - last_evt) > 6) begin
            es = {2'b00, (rst ? 1'b0 : m_trig), m_armed(), m_any, m_bits};
            chk("cycle_status", 32'(monitor_status), 32'(es));
            chk("cycle_laser", 32'(laser_enable), 32'(m_armed()));
            chk_near("cycle_width", last_width, m_lw);
            chk_near("cycle_period", last_period, m_lp);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        last_evt = cyc;
    endtask

    task automatic fault(input int b);
        m_bits[b] = 1'b1;
        m_any     = 1'b1;
        m_state   = S_FAULT;
    endtask

    task automatic set_trig(input logic v);
        int t;
        mark();
        trig_in = v;
        m_trig  = v;
        if (v) begin
            if (m_state == S_WAIT) m_state = S_HIGH;
            else if (m_state == S_LOW) begin
                t = (cyc - rise_cyc) / 8;
                m_lp = t;
                if (t < int'(rlim)) fault(2);
                else m_state = S_HIGH;
            end
            rise_cyc = cyc;
        end else if (m_state == S_HIGH) begin
            t = (cyc - rise_cyc) / 8;
            m_lw = t;
            if (t < int'(pwl)) fault(0);
            else m_state = S_LOW;
        end
    endtask

    task automatic set_en(input logic v);
        mark();
        monitor_enable = v;
        if (!v) m_state = S_DIS;
        else if (m_state == S_DIS) m_state = S_WAIT;
    endtask

    task automatic set_lim(input int up, input int lo, input int rt);
        mark();
        pwu = up; pwl = lo; rlim = rt;
    endtask

    task automatic do_clear();
        mark();
        fault_clear = 1'b1;
        m_bits = '0;
        m_any  = 1'b0;
        if (m_state == S_FAULT) m_state = monitor_enable ? S_WAIT : S_DIS;
        clks(2);
        fault_clear = 1'b0;
    endtask

    // one pulse of w ticks high followed by lo ticks low
    task automatic pulse(input int w, input int lo);
        set_trig(1'b1);
        if (m_state == S_HIGH && w > int'(pwu)) begin
            clks((int'(pwu) - 1) * 8);
            mute = 1'b1;
            clks(4 * 8);
            mark();
            fault(1);
            mute = 1'b0;
            clks((w - int'(pwu) - 3) * 8);
        end else begin
            clks(w * 8);
        end
        set_trig(1'b0);
        clks(lo * 8);
    endtask

    initial begin : watchdog
        #6000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w, p;
        rst = 1'b1; trig_in = 1'b0; monitor_enable = 1'b0; fault_clear = 1'b0;
        pwu = 860; pwl = 0; rlim = 70313;
        mark();
        clks(3);
        // reset and arm
        chk("reset_status", 32'(monitor_status), 32'h00);
        chk("reset_laser", 32'(laser_enable), 32'h0);
        chk("reset_width", last_width, 32'h0);
        chk("reset_period", last_period, 32'h0);
        mark();
        rst = 1'b0;
        clks(3);
        set_en(1'b1);
        clks(1);
        chk("arm_after_1clk", 32'(laser_enable), 32'h0);
        clks(1);
        chk("arm_after_2clk", 32'(laser_enable), 32'h1);
        chk("arm_status", 32'(monitor_status), 32'h10);

        // legal train
        set_lim(860, 0, 500);
        clks(10);
        repeat (3) pulse(300, 300);
        chk_near("train_width", last_width, 300);
        chk_near("train_period", last_period, 600);
        chk("train_status", 32'(monitor_status), 32'h10);

        // long pulse: fault while the trigger is still high
        set_trig(1'b1);
        clks(855 * 8);
        chk("long_before_limit", 32'(monitor_status), 32'h30);
        mute = 1'b1;
        clks(10 * 8);
        mark();
        fault(1);
        mute = 1'b0;
        chk("long_status_high", 32'(monitor_status), 32'h2A);
        chk("long_laser", 32'(laser_enable), 32'h0);
        clks(135 * 8);
        set_trig(1'b0);
        clks(20 * 8);
        chk("long_status_low", 32'(monitor_status), 32'h0A);
        do_clear();
        chk("clear_status", 32'(monitor_status), 32'h10);
        chk("clear_laser", 32'(laser_enable), 32'h1);

        // rate violation on the second rise
        set_lim(860, 0, 400);
        clks(20);
        pulse(100, 200);
        set_trig(1'b1);
        clks(10);
        chk("rate_status_high", 32'(monitor_status), 32'h2C);
        chk_near("rate_period", last_period, 300);
        clks(100 * 8 - 10);
        set_trig(1'b0);
        clks(10);
        chk("rate_status_low", 32'(monitor_status), 32'h0C);
        do_clear();
        // first pulse after a clear is never rate-checked
        clks(10 * 8 - 2);
        set_trig(1'b1);
        clks(16);
        chk("no_rate_after_clear", 32'(monitor_status), 32'h30);
        clks(50 * 8 - 16);
        set_trig(1'b0);
        clks(500 * 8);

        // short pulse, rate check disabled
        set_lim(860, 100, 0);
        pulse(50, 30);
        chk("short_status", 32'(monitor_status), 32'h09);
        chk_near("short_width", last_width, 50);
        do_clear();
        set_lim(860, 0, 0);
        pulse(150, 10);
        pulse(150, 10);
        chk("rate_zero_status", 32'(monitor_status), 32'h10);
        chk_near("rate_zero_period", last_period, 160);

        // clear edge coinciding with a new violation
        set_trig(1'b1);
        clks(20 * 8);
        mute = 1'b1;
        fault_clear = 1'b1;
        clks(1);
        pwu = 0;
        clks(3);
        mark();
        fault(1);
        mute = 1'b0;
        chk("clear_vs_violation", 32'(monitor_status), 32'h2A);
        fault_clear = 1'b0;
        set_lim(860, 0, 0);
        clks(4);
        // disabling from fault keeps the sticky bits
        set_en(1'b0);
        clks(4);
        chk("disable_keeps_sticky", 32'(monitor_status), 32'h2A);
        chk("disable_laser", 32'(laser_enable), 32'h0);
        clks(8);
        // reset in the middle of a pulse
        mark();
        rst = 1'b1;
        m_state = S_DIS; m_bits = '0; m_any = 1'b0; m_lw = 0; m_lp = 0;
        clks(2);
        chk("midreset_status", 32'(monitor_status), 32'h00);
        chk("midreset_laser", 32'(laser_enable), 32'h0);
        chk("midreset_width", last_width, 32'h0);
        chk("midreset_period", last_period, 32'h0);
        set_trig(1'b0);
        clks(2);
        mark();
        rst = 1'b0;
        clks(4);
        set_en(1'b1);
        clks(8);

        // randomized pulses, kept clear of the +-1 tick quantization band
        set_lim(60, 10, 100);
        clks(8);
        for (int i = 0; i < 25; i++) begin
            do w = $urandom_range(80, 2); while ((w >= 8 && w <= 12) || (w >= 58 && w <= 62));
            do p = $urandom_range(180, 40); while ((p >= 98 && p <= 102) || p < w + 3);
            pulse(w, p - w);
            if (m_state == S_FAULT) begin
                clks(4);
                do_clear();
                clks(8);
            end
        end
        clks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
